// File: rtl/async_transmitter_fifo_pkg.sv
// Shared definitions for the serial link: transmitter state encoding and
// the fractional baud-increment calculation also used by the receiver.
package async_transmitter_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int FrameDataBits = 8;

    // Rounded increment so that the accumulator MSB overflows at the baud rate.
    function automatic longint baud_inc(input longint clk_hz, input longint baud, input int acc_w);
        return ((baud << (acc_w - 4)) + (clk_hz >> 5)) / (clk_hz >> 4);
    endfunction

endpackage

// File: rtl/async_transmitter_fifo_if.sv
// Host-side byte interface of the serial transmitter: push handshake,
// serial line and queue status.
interface async_transmitter_fifo_if #(
    parameter int FifoAddrWidth = 4
) ();
    logic [7:0]             TxD_data;
    logic                   TxD_start;
    logic                   TxD_ready;
    logic                   TxD;
    logic                   TxD_busy;
    logic [FifoAddrWidth:0] fifo_level;

    modport master (
        output TxD_data,
        output TxD_start,
        input  TxD_ready,
        input  TxD,
        input  TxD_busy,
        input  fifo_level
    );

    modport slave (
        input  TxD_data,
        input  TxD_start,
        output TxD_ready,
        output TxD,
        output TxD_busy,
        output fifo_level
    );
endinterface

// File: rtl/async_transmitter_fifo_sync_fifo.sv
// Single-clock show-ahead FIFO: the head word is visible on o_data while
// not empty, so a pop consumes it in the same cycle.
module async_transmitter_fifo_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_level
);
    localparam int              Depth  = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DepthL = Depth[ADDR_W:0];

    logic [DATA_W-1:0] r_mem [Depth];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_level == DepthL);
    assign w_empty = (r_level == '0);
    // A push while full is refused even if a pop frees a slot this cycle.
    assign w_push  = i_push & ~w_full;
    assign w_pop   = i_pop  & ~w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_level;

endmodule

// File: rtl/async_transmitter_fifo.sv
// RS-232 8N1 transmitter with input FIFO: fractional baud accumulator,
// frame FSM and registered line output; frames go out back-to-back.
module async_transmitter_fifo
    import async_transmitter_fifo_pkg::*;
#(
    parameter int ClkFrequency  = 33333333,
    parameter int Baud          = 115200,
    parameter int BaudAccWidth  = 16,
    parameter int FifoAddrWidth = 4,
    parameter int StopBits      = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    async_transmitter_fifo_if.slave bus
);
    localparam longint                BaudIncFull = baud_inc(ClkFrequency, Baud, BaudAccWidth);
    localparam logic [BaudAccWidth:0] BaudInc     = BaudIncFull[BaudAccWidth:0];
    localparam logic                  StopLast    = (StopBits == 2);
    localparam logic [2:0]            LastBit     = 3'(FrameDataBits - 1);

    tx_state_e             r_state;
    logic [BaudAccWidth:0] r_acc;
    logic [7:0]            r_shift;
    logic [2:0]            r_bitcnt;
    logic                  r_stopcnt;
    logic                  r_txd;

    logic                   w_tick;
    logic                   w_stop_last;
    logic                   w_pop;
    logic [7:0]             w_fifo_data;
    logic                   w_full;
    logic                   w_empty;
    logic [FifoAddrWidth:0] w_level;

    async_transmitter_fifo_sync_fifo #(
        .DATA_W (8),
        .ADDR_W (FifoAddrWidth)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (bus.TxD_start),
        .i_data  (bus.TxD_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign w_tick      = r_acc[BaudAccWidth];
    assign w_stop_last = (r_stopcnt == StopLast);
    assign w_pop       = ((r_state == ST_IDLE) && !w_empty) ||
                         ((r_state == ST_STOP) && w_tick && w_stop_last && !w_empty);

    // Held at zero while idle; counting starts on the pop edge so the start bit is a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if ((r_state == ST_IDLE) && !w_pop) begin
            r_acc <= '0;
        end else begin
            r_acc <= {1'b0, r_acc[BaudAccWidth-1:0]} + BaudInc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_txd     <= 1'b1;
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_stopcnt <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_fifo_data;
                        r_txd   <= 1'b0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_txd    <= r_shift[0];
                        r_shift  <= {1'b0, r_shift[7:1]};
                        r_bitcnt <= '0;
                        r_state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_bitcnt == LastBit) begin
                            r_txd     <= 1'b1;
                            r_stopcnt <= 1'b0;
                            r_state   <= ST_STOP;
                        end else begin
                            r_txd    <= r_shift[0];
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_bitcnt <= r_bitcnt + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        if (!w_stop_last) begin
                            r_stopcnt <= r_stopcnt + 1'b1;
                        end else if (w_pop) begin
                            // Next frame starts straight out of the stop bit, no idle gap.
                            r_shift <= w_fifo_data;
                            r_txd   <= 1'b0;
                            r_state <= ST_START;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.TxD        = r_txd;
    assign bus.TxD_ready  = ~w_full;
    assign bus.TxD_busy   = (r_state != ST_IDLE) | (w_level != '0);
    assign bus.fifo_level = w_level;

endmodule

// File: tb/tb_async_transmitter_fifo.sv
// Bench for the FIFO serial transmitter: line decoder model, byte
// scoreboards and timing checks at 16 clk per bit.
module tb_async_transmitter_fifo;

    localparam int ClkHz = 1600000;
    localparam int BaudR = 100000;
    localparam int Bit   = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    async_transmitter_fifo_if #(.FifoAddrWidth(4)) bus1 ();
    async_transmitter_fifo_if #(.FifoAddrWidth(4)) bus2 ();

    async_transmitter_fifo #(
        .ClkFrequency(ClkHz), .Baud(BaudR), .BaudAccWidth(16), .FifoAddrWidth(4), .StopBits(1)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    async_transmitter_fifo #(
        .ClkFrequency(ClkHz), .Baud(BaudR), .BaudAccWidth(16), .FifoAddrWidth(4), .StopBits(2)
    ) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model on dut1's line: sample at bit centres after each falling edge.
    logic [7:0] rx_q[$];
    int         rx_t[$];
    int         rx_err = 0;
    bit         rx_active = 0;
    int         rx_cnt;
    int         rx_start;
    logic [7:0] rx_byte;
    bit         rx_bad;

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_active = 0;
        end else if (!rx_active) begin
            if (bus1.TxD === 1'b0) begin
                rx_active = 1;
                rx_cnt    = 0;
                rx_start  = cyc;
                rx_bad    = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt >= Bit / 2 && ((rx_cnt - Bit / 2) % Bit) == 0) begin
                int k;
                k = (rx_cnt - Bit / 2) / Bit;
                if (k == 0) begin
                    if (bus1.TxD !== 1'b0) rx_bad = 1;
                end else if (k <= 8) begin
                    rx_byte[k-1] = bus1.TxD;
                end else begin
                    if (bus1.TxD !== 1'b1) rx_bad = 1;
                    if (rx_bad) rx_err++;
                    rx_q.push_back(rx_byte);
                    rx_t.push_back(rx_start);
                    rx_active = 0;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d expected below 20000", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic tick_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_t.delete();
        rx_err = 0;
    endtask

    task automatic wait_not_busy(input int limit, output bit ok);
        int n;
        n = 0;
        while (bus1.TxD_busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        ok = (bus1.TxD_busy === 1'b0);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus1.TxD, bus1.TxD_busy, bus1.TxD_ready} !== 3'b101 || bus1.fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL reset_in: got TxD/busy/ready=%b%b%b level=%0d expected 101 level=0",
                     bus1.TxD, bus1.TxD_busy, bus1.TxD_ready, bus1.fifo_level);
        end
        rst_n = 1'b1;
        bus1.TxD_start = 1'b0; bus1.TxD_data = '0;
        bus2.TxD_start = 1'b0; bus2.TxD_data = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if ({bus1.TxD, bus1.TxD_busy, bus1.TxD_ready} !== 3'b101 || bus1.fifo_level !== 5'd0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got TxD/busy/ready=%b%b%b level=%0d expected 101 level=0",
                         i, bus1.TxD, bus1.TxD_busy, bus1.TxD_ready, bus1.fifo_level);
            end
        end
        $display("test_reset: idle checked for 100 cycles");
    endtask

    task automatic test_single_frame();
        logic [7:0] d;
        logic       exp_bit;
        int         n;
        d = 8'hA5;
        clear_rx();
        bus1.TxD_data = d; bus1.TxD_start = 1'b1;
        @(negedge clk);
        bus1.TxD_start = 1'b0;
        n = cyc;
        checks++;
        if (bus1.TxD !== 1'b1 || bus1.fifo_level !== 5'd1 || bus1.TxD_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_push: got TxD=%b level=%0d busy=%b expected 1,1,1",
                     bus1.TxD, bus1.fifo_level, bus1.TxD_busy);
        end
        @(negedge clk);
        checks++;
        if (bus1.TxD !== 1'b0 || bus1.fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL single_latency: got TxD=%b level=%0d expected 0,0", bus1.TxD, bus1.fifo_level);
        end
        for (int k = 0; k < 10; k++) begin
            tick_to(n + 1 + Bit / 2 + Bit * k);
            exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : d[k-1];
            checks++;
            if (bus1.TxD !== exp_bit) begin
                errors++;
                $display("FAIL single_bit[%0d]: got %b expected %b", k, bus1.TxD, exp_bit);
            end
        end
        tick_to(n + 160);
        checks++;
        if (bus1.TxD_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_end: got %b expected 1", bus1.TxD_busy);
        end
        tick_to(n + 161);
        checks++;
        if (bus1.TxD_busy !== 1'b0 || bus1.TxD !== 1'b1) begin
            errors++;
            $display("FAIL single_done: got busy=%b TxD=%b expected 0,1", bus1.TxD_busy, bus1.TxD);
        end
        checks++;
        if (rx_q.size() != 1 || rx_err != 0 || (rx_q.size() == 1 && rx_q[0] !== d)) begin
            errors++;
            $display("FAIL single_decode: got %0d frames err=%0d expected 1 frame 0x%h", rx_q.size(), rx_err, d);
        end
        $display("test_single_frame: sent 0x%h", d);
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        int  t0;
        bit  ok;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55;
        clear_rx();
        t0 = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            bus1.TxD_data = bytes[i]; bus1.TxD_start = 1'b1;
            @(negedge clk);
        end
        bus1.TxD_start = 1'b0;
        wait_not_busy(600, ok);
        checks++;
        if (!ok || cyc != t0 + 1 + 480) begin
            errors++;
            $display("FAIL b2b_length: got done=%b at %0d clk after start expected 480", ok, cyc - t0 - 1);
        end
        checks++;
        if (rx_q.size() != 3 || rx_err != 0) begin
            errors++;
            $display("FAIL b2b_count: got %0d frames err=%0d expected 3 frames err=0", rx_q.size(), rx_err);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rx_q[i] !== bytes[i] || rx_t[i] != t0 + 1 + 160 * i) begin
                    errors++;
                    $display("FAIL b2b_frame[%0d]: got 0x%h at %0d expected 0x%h at %0d",
                             i, rx_q[i], rx_t[i], bytes[i], t0 + 1 + 160 * i);
                end
            end
        end
        $display("test_back_to_back: 3 frames, %0d decoded", rx_q.size());
    endtask

    task automatic test_fill();
        int         mdl_lvl;
        logic [7:0] exp_q[$];
        logic [7:0] d;
        bit         exp_ready;
        bit         ok;
        mdl_lvl = 0;
        clear_rx();
        for (int i = 0; i < 18; i++) begin
            exp_ready = (mdl_lvl < 16);
            checks++;
            if (bus1.TxD_ready !== exp_ready || bus1.fifo_level !== 5'(mdl_lvl)) begin
                errors++;
                $display("FAIL fill_ready[%0d]: got ready=%b level=%0d expected %b level=%0d",
                         i, bus1.TxD_ready, bus1.fifo_level, exp_ready, mdl_lvl);
            end
            d = 8'($urandom);
            bus1.TxD_data = d; bus1.TxD_start = 1'b1;
            @(negedge clk);
            if (i == 1) mdl_lvl--;
            if (exp_ready) begin
                mdl_lvl++;
                exp_q.push_back(d);
            end
        end
        bus1.TxD_start = 1'b0;
        checks++;
        if (bus1.fifo_level !== 5'd16 || bus1.TxD_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: got level=%0d ready=%b expected 16,0", bus1.fifo_level, bus1.TxD_ready);
        end
        wait_not_busy(17 * 160 + 50, ok);
        checks++;
        if (!ok || rx_q.size() != exp_q.size() || rx_err != 0) begin
            errors++;
            $display("FAIL fill_drain: got done=%b frames=%0d err=%0d expected 1,%0d,0",
                     ok, rx_q.size(), rx_err, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (rx_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL fill_order[%0d]: got 0x%h expected 0x%h", i, rx_q[i], exp_q[i]);
                end
            end
        end
        $display("test_fill: %0d accepted, %0d decoded", exp_q.size(), rx_q.size());
    endtask

    task automatic test_push_pop();
        logic [7:0] exp_q[$];
        logic [7:0] d;
        int         m;
        bit         ok;
        clear_rx();
        m = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            bus1.TxD_data = d; bus1.TxD_start = 1'b1;
            @(negedge clk);
            exp_q.push_back(d);
        end
        bus1.TxD_start = 1'b0;
        tick_to(m + 160);
        checks++;
        if (bus1.fifo_level !== 5'd3) begin
            errors++;
            $display("FAIL pp_pre: got level=%0d expected 3", bus1.fifo_level);
        end
        d = 8'($urandom);
        bus1.TxD_data = d; bus1.TxD_start = 1'b1;
        @(negedge clk);
        exp_q.push_back(d);
        checks++;
        if (bus1.fifo_level !== 5'd3) begin
            errors++;
            $display("FAIL pp_same_edge: got level=%0d expected 3", bus1.fifo_level);
        end
        for (int i = 0; i < 13; i++) begin
            d = 8'($urandom);
            bus1.TxD_data = d;
            @(negedge clk);
            exp_q.push_back(d);
        end
        bus1.TxD_start = 1'b0;
        checks++;
        if (bus1.fifo_level !== 5'd16 || bus1.TxD_ready !== 1'b0) begin
            errors++;
            $display("FAIL pp_full: got level=%0d ready=%b expected 16,0", bus1.fifo_level, bus1.TxD_ready);
        end
        tick_to(m + 320);
        bus1.TxD_data = 8'($urandom); bus1.TxD_start = 1'b1;
        @(negedge clk);
        bus1.TxD_start = 1'b0;
        checks++;
        if (bus1.fifo_level !== 5'd15) begin
            errors++;
            $display("FAIL pp_full_refuse: got level=%0d expected 15", bus1.fifo_level);
        end
        wait_not_busy(17 * 160 + 50, ok);
        checks++;
        if (!ok || rx_q.size() != exp_q.size() || rx_err != 0) begin
            errors++;
            $display("FAIL pp_drain: got done=%b frames=%0d err=%0d expected 1,%0d,0",
                     ok, rx_q.size(), rx_err, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (rx_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL pp_order[%0d]: got 0x%h expected 0x%h", i, rx_q[i], exp_q[i]);
                end
            end
        end
        $display("test_push_pop: %0d bytes expected, %0d decoded", exp_q.size(), rx_q.size());
    endtask

    task automatic test_mid_frame_reset();
        logic [7:0] d;
        int         n;
        bit         ok;
        clear_rx();
        bus1.TxD_data = 8'h00; bus1.TxD_start = 1'b1;
        @(negedge clk);
        n = cyc;
        repeat (2) begin
            bus1.TxD_data = 8'($urandom);
            @(negedge clk);
        end
        bus1.TxD_start = 1'b0;
        tick_to(n + 1 + Bit * 5 + Bit / 2);
        checks++;
        if (bus1.TxD !== 1'b0 || bus1.fifo_level !== 5'd2) begin
            errors++;
            $display("FAIL rst_pre: got TxD=%b level=%0d expected 0,2", bus1.TxD, bus1.fifo_level);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus1.TxD !== 1'b1 || bus1.fifo_level !== 5'd0 || bus1.TxD_busy !== 1'b0 || bus1.TxD_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_async: got TxD=%b level=%0d busy=%b ready=%b expected 1,0,0,1",
                     bus1.TxD, bus1.fifo_level, bus1.TxD_busy, bus1.TxD_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        clear_rx();
        d = 8'($urandom);
        bus1.TxD_data = d; bus1.TxD_start = 1'b1;
        @(negedge clk);
        bus1.TxD_start = 1'b0;
        n = cyc;
        @(negedge clk);
        checks++;
        if (bus1.TxD !== 1'b0) begin
            errors++;
            $display("FAIL rst_restart: got TxD=%b expected 0", bus1.TxD);
        end
        wait_not_busy(300, ok);
        checks++;
        if (!ok || cyc != n + 161 || rx_q.size() != 1 || rx_err != 0 || (rx_q.size() == 1 && rx_q[0] !== d)) begin
            errors++;
            $display("FAIL rst_clean_frame: got done=%b len=%0d frames=%0d err=%0d expected len 160, 1 frame 0x%h",
                     ok, cyc - n - 1, rx_q.size(), rx_err, d);
        end
        $display("test_mid_frame_reset: recovered with 0x%h", d);
    endtask

    task automatic test_two_stop();
        logic [7:0] d;
        logic       exp_bit;
        int         n;
        d = 8'($urandom) & 8'h7F;
        bus2.TxD_data = d; bus2.TxD_start = 1'b1;
        @(negedge clk);
        bus2.TxD_start = 1'b0;
        n = cyc;
        for (int k = 0; k < 9; k++) begin
            tick_to(n + 1 + Bit / 2 + Bit * k);
            exp_bit = (k == 0) ? 1'b0 : d[k-1];
            checks++;
            if (bus2.TxD !== exp_bit) begin
                errors++;
                $display("FAIL stop2_bit[%0d]: got %b expected %b", k, bus2.TxD, exp_bit);
            end
        end
        tick_to(n + 144);
        checks++;
        if (bus2.TxD !== 1'b0) begin
            errors++;
            $display("FAIL stop2_last_data: got %b expected 0", bus2.TxD);
        end
        for (int i = 0; i < 32; i++) begin
            tick_to(n + 145 + i);
            checks++;
            if (bus2.TxD !== 1'b1 || bus2.TxD_busy !== 1'b1) begin
                errors++;
                $display("FAIL stop2_high[%0d]: got TxD=%b busy=%b expected 1,1", i, bus2.TxD, bus2.TxD_busy);
            end
        end
        tick_to(n + 177);
        checks++;
        if (bus2.TxD_busy !== 1'b0 || bus2.TxD !== 1'b1) begin
            errors++;
            $display("FAIL stop2_end: got busy=%b TxD=%b expected 0,1", bus2.TxD_busy, bus2.TxD);
        end
        $display("test_two_stop: sent 0x%h with 2 stop bits", d);
    endtask

    initial begin
        bus1.TxD_start = 1'b0; bus1.TxD_data = '0;
        bus2.TxD_start = 1'b0; bus2.TxD_data = '0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_fill();
        test_push_pop();
        test_mid_frame_reset();
        test_two_stop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
